// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the I/D BRAM arbiter.
package mem_pkg;
  localparam int BRAM_ADDR_W      = 15;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } rsp_owner_e;

  // Returns 1 when the access must be flagged as an error.
  // Partial-lane writes may use any byte offset; full-word accesses must be aligned.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [3:0] we, input int aw);
    logic full_word;
    logic misaligned;
    logic out_of_range;
    full_word    = (we == 4'h0) || (we == 4'hF);
    misaligned   = full_word && (addr[1:0] != 2'b00);
    out_of_range = (addr >> (aw + 2)) != 32'd0;
    return misaligned || out_of_range;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the pipeline ports, the arbiter and the BRAM.
interface mem_arbiter_if #(parameter int ADDR_W = 15);
  logic              i_req_valid;
  logic              i_req_ready;
  logic [31:0]       i_req_addr;
  logic              i_rsp_valid;
  logic [31:0]       i_rsp_data;
  logic              i_rsp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [31:0]       d_req_addr;
  logic [3:0]        d_req_we;
  logic [31:0]       d_req_wdata;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              d_rsp_err;

  logic [3:0]        mem_w_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_w_data;
  logic [31:0]       mem_r_data;

  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata,
    input  mem_r_data,
    output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_w_enable, mem_addr, mem_w_data
  );

  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata,
    output mem_r_data,
    input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_w_enable, mem_addr, mem_w_data
  );
endinterface

// File: rtl/mem_arbiter_prio.sv
// D-over-I priority grant with a starvation counter that forces an I grant.
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic d_valid,
  output logic grant_i,
  output logic grant_d
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;
  logic          force_i;

  assign force_i = i_valid && (starve_cnt == LIMIT);
  assign grant_i = !rst && i_valid && (!d_valid || force_i);
  assign grant_d = !rst && d_valid && !grant_i;

  always_comb begin
    starve_nxt = starve_cnt;
    if (grant_i || !i_valid)
      starve_nxt = '0;
    else if (grant_d && (starve_cnt != LIMIT))
      starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else
      starve_cnt <= starve_nxt;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port BRAM between fetch (I) and load/store (D); responses
// return one cycle after grant, tagged to the granted requester.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = BRAM_ADDR_W,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);
  logic       grant_i;
  logic       grant_d;
  logic       i_err;
  logic       d_err;
  rsp_owner_e owner_q;
  rsp_owner_e owner_d;
  logic       err_q;
  logic       err_d;

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.i_req_valid),
    .d_valid (bus.d_req_valid),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  assign i_err = addr_ok(bus.i_req_addr, 4'h0, ADDR_W);
  assign d_err = addr_ok(bus.d_req_addr, bus.d_req_we, ADDR_W);

  assign bus.i_req_ready = grant_i;
  assign bus.d_req_ready = grant_d;
  assign bus.mem_w_data  = bus.d_req_wdata;

  always_comb begin
    owner_d          = OWN_NONE;
    err_d            = 1'b0;
    bus.mem_w_enable = 4'h0;
    bus.mem_addr     = bus.d_req_addr[ADDR_W+1:2];
    if (grant_i) begin
      owner_d      = OWN_I;
      err_d        = i_err;
      bus.mem_addr = bus.i_req_addr[ADDR_W+1:2];
    end else if (grant_d) begin
      owner_d = OWN_D;
      err_d   = d_err;
      if (!d_err)
        bus.mem_w_enable = bus.d_req_we;
    end
  end

  // Reset clears the owner, which drops any response already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  assign bus.i_rsp_valid = (owner_q == OWN_I);
  assign bus.i_rsp_err   = (owner_q == OWN_I) && err_q;
  assign bus.i_rsp_data  = ((owner_q == OWN_I) && !err_q) ? bus.mem_r_data : 32'h0;

  assign bus.d_rsp_valid = (owner_q == OWN_D);
  assign bus.d_rsp_err   = (owner_q == OWN_D) && err_q;
  assign bus.d_rsp_data  = ((owner_q == OWN_D) && !err_q) ? bus.mem_r_data : 32'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized plus directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW    = 15;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // BRAM macro: registered read, byte-lane writes.
  logic [31:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    bus.mem_r_data <= bram[bus.mem_addr];
    for (int b = 0; b < 4; b++)
      if (bus.mem_w_enable[b]) bram[bus.mem_addr][8*b +: 8] <= bus.mem_w_data[8*b +: 8];
  end

  // Reference model state
  logic [31:0] ref_mem [0:15];
  int          exp_owner = 0;   // 0 none, 1 I, 2 D
  bit          exp_err   = 0;
  bit          exp_store = 0;
  logic [31:0] exp_data  = 0;
  int          starve    = 0;
  bit          last_gi, last_gd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [3:0] we);
    bit full = (we == 4'h0) || (we == 4'hF);
    return (full && (a % 4 != 0)) || (a >= (32'h1 << (AW + 2)));
  endfunction

  task automatic step(input bit iv, input logic [31:0] ia, input bit dv,
                      input logic [31:0] da, input logic [3:0] dwe, input logic [31:0] dwd);
    bit gi, gd, err;
    logic [31:0] a;
    int w;
    @(negedge clk);
    chk("i_rsp_valid", 32'(bus.i_rsp_valid), 32'(exp_owner == 1));
    chk("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(exp_owner == 2));
    chk("i_rsp_err", 32'(bus.i_rsp_err), 32'(exp_owner == 1 && exp_err));
    chk("d_rsp_err", 32'(bus.d_rsp_err), 32'(exp_owner == 2 && exp_err));
    if (exp_owner == 1) chk("i_rsp_data", bus.i_rsp_data, exp_data);
    if (exp_owner == 2 && !exp_store) chk("d_rsp_data", bus.d_rsp_data, exp_data);

    bus.i_req_valid = iv;  bus.i_req_addr  = ia;
    bus.d_req_valid = dv;  bus.d_req_addr  = da;
    bus.d_req_we    = dwe; bus.d_req_wdata = dwd;
    #1;
    gi = iv && (!dv || starve == LIMIT);
    gd = dv && !gi;
    chk("i_req_ready", 32'(bus.i_req_ready), 32'(gi));
    chk("d_req_ready", 32'(bus.d_req_ready), 32'(gd));
    a   = gi ? ia : da;
    err = gi ? is_err(ia, 4'h0) : is_err(da, dwe);
    if (gi || gd) chk("mem_addr", 32'(bus.mem_addr), (a / 4) % (1 << AW));
    chk("mem_w_enable", 32'(bus.mem_w_enable), (gd && !err) ? 32'(dwe) : 32'h0);
    if (gd && !err && dwe != 0) chk("mem_w_data", bus.mem_w_data, dwd);

    exp_owner = gi ? 1 : (gd ? 2 : 0);
    exp_err   = (gi || gd) && err;
    exp_store = gd && (dwe != 0);
    w         = (a / 4) % 16;
    exp_data  = err ? 32'h0 : ref_mem[w];
    if (gd && !err)
      for (int b = 0; b < 4; b++)
        if (dwe[b]) ref_mem[w][8*b +: 8] = dwd[8*b +: 8];
    if (gi || !iv) starve = 0;
    else if (gd && starve < LIMIT) starve++;
    last_gi = gi;
    last_gd = gd;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    a = 32'($urandom_range(0, 15)) * 4;
    if (r == 0) a = a + 32'($urandom_range(1, 3));
    else if (r == 1) a = a | (32'h0002_0000 << $urandom_range(0, 14));
    return a;
  endfunction

  function automatic logic [3:0] rnd_we();
    int r;
    r = $urandom_range(0, 3);
    if (r < 2) return 4'h0;
    if (r == 2) return 4'hF;
    return 4'($urandom_range(1, 15));
  endfunction

  initial begin
    bit          ip, dp;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dwe;
    logic [5:0]  seq;

    for (int k = 0; k < 16; k++) ref_mem[k] = 32'h0;
    rst = 1'b1;
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h4;
    bus.d_req_we = 4'hF;    bus.d_req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_i_ready", 32'(bus.i_req_ready), 32'h0);
    chk("rst_d_ready", 32'(bus.d_req_ready), 32'h0);
    chk("rst_wen", 32'(bus.mem_w_enable), 32'h0);
    chk("rst_rsp_valid", {30'h0, bus.i_rsp_valid, bus.d_rsp_valid}, 32'h0);
    chk("rst_rsp_err", {30'h0, bus.i_rsp_err, bus.d_rsp_err}, 32'h0);
    chk("rst_i_data", bus.i_rsp_data, 32'h0);
    chk("rst_d_data", bus.d_rsp_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_req_valid = 1'b0; bus.d_req_valid = 1'b0;

    // Preload words 0..15 through the arbiter
    for (int k = 0; k < 16; k++)
      step(0, 0, 1, 32'(k * 4), 4'hF, (k == 4) ? 32'hDEAD_BEEF : $urandom);

    // Single fetch
    step(1, 32'h10, 0, 0, 0, 0);
    chk("tp1_ready", 32'(bus.i_req_ready), 32'h1);
    chk("tp1_addr", 32'(bus.mem_addr), 32'h4);
    step(0, 0, 0, 0, 0, 0);
    chk("tp1_data", bus.i_rsp_data, 32'hDEAD_BEEF);
    chk("tp1_dvalid", 32'(bus.d_rsp_valid), 32'h0);

    // Half-word store then read back
    step(0, 0, 1, 32'h20, 4'b0011, 32'h1234_5678);
    chk("tp2_wen", 32'(bus.mem_w_enable), 32'h3);
    chk("tp2_addr", 32'(bus.mem_addr), 32'h8);
    step(0, 0, 1, 32'h20, 4'h0, 0);
    chk("tp2_ack", 32'(bus.d_rsp_valid), 32'h1);
    step(0, 0, 0, 0, 0, 0);
    chk("tp2_low", 32'(bus.d_rsp_data[15:0]), 32'h5678);

    // Starvation: D,D,D,D,I,D
    for (int k = 0; k < 6; k++) begin
      step(1, 32'h0, 1, 32'h4, 4'h0, 0);
      seq[k] = bus.i_req_ready;
    end
    chk("tp3_seq", 32'(seq), 32'b010000);
    step(1, 32'h0, 1, 32'h4, 4'h0, 0);
    chk("tp3_cleared", 32'(bus.d_req_ready), 32'h1);
    step(0, 0, 0, 0, 0, 0);

    // Error cases
    step(0, 0, 1, 32'h0002_0000, 4'hF, 32'hCAFE_F00D);
    chk("tp4_oor_store_wen", 32'(bus.mem_w_enable), 32'h0);
    step(0, 0, 1, 32'h0002_0000, 4'h0, 0);
    chk("tp4_oor_read_wen", 32'(bus.mem_w_enable), 32'h0);
    step(1, 32'h2, 0, 0, 0, 0);
    chk("tp4_d_err", 32'(bus.d_rsp_err), 32'h1);
    chk("tp4_d_data", bus.d_rsp_data, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("tp4_i_err", 32'(bus.i_rsp_err), 32'h1);
    chk("tp4_i_data", bus.i_rsp_data, 32'h0);

    // Back-to-back reads
    step(0, 0, 1, 32'h0, 4'h0, 0);
    step(0, 0, 1, 32'h4, 4'h0, 0);
    chk("tp5_r0", bus.d_rsp_data, ref_mem[0]);
    step(0, 0, 1, 32'h8, 4'h0, 0);
    chk("tp5_r1", bus.d_rsp_data, ref_mem[1]);
    step(0, 0, 0, 0, 0, 0);
    chk("tp5_r2", bus.d_rsp_data, ref_mem[2]);

    // Reset right after an I grant drops the response
    step(1, 32'h10, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("tp6_rsp_drop", 32'(bus.i_rsp_valid), 32'h0);
    chk("tp6_data_drop", bus.i_rsp_data, 32'h0);
    chk("tp6_no_grant", 32'(bus.i_req_ready), 32'h0);
    exp_owner = 0; exp_err = 0; starve = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.i_req_valid = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Random traffic with hold-until-accepted requesters
    ip = 0; dp = 0; ia = 0; da = 0; dwe = 0; dwd = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1; ia = rnd_addr();
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; da = rnd_addr(); dwe = rnd_we(); dwd = $urandom;
      end
      step(ip, ia, dp, da, dwe, dwd);
      if (last_gi) ip = 0;
      if (last_gd) dp = 0;
    end
    step(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data/instruction BRAM between two requesters: the instruction-fetch port (I) and the load/store port (D).
- Accepts byte-addressed requests over valid/ready handshakes and converts them to word-addressed BRAM accesses with byte write enables.
- Returns read data one cycle after grant, tagged to the granted requester.
- Sits between the pipeline front-end/MEM stage and the BRAM macro.

Parameters:
- ADDR_W, 15, word-address width; BRAM depth is 2**ADDR_W words (32768).
- STARVE_LIMIT, 4, max consecutive D grants while I is waiting before I is forced.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  fetch request.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  32  fetch byte address.
- i_rsp_valid  out  1  fetch data valid.
- i_rsp_data  out  32  fetch word.
- i_rsp_err  out  1  fetch was misaligned or out of range.
- d_req_valid  in  1  load/store request.
- d_req_ready  out  1  load/store accepted this cycle.
- d_req_addr  in  32  byte address.
- d_req_we  in  4  byte write enables; 0 means read.
- d_req_wdata  in  32  store data, already lane-aligned.
- d_rsp_valid  out  1  load data valid or store ack.
- d_rsp_data  out  32  load word; undefined for stores.
- d_rsp_err  out  1  access was misaligned or out of range.
- mem_w_enable  out  4  BRAM byte write enables.
- mem_addr  out  ADDR_W  BRAM word address, driving both r_addr and w_addr.
- mem_w_data  out  32  BRAM write data.
- mem_r_data  in  32  BRAM registered read data, valid one cycle after the address.

Behaviour:
- Grant is combinational from the current valids and registered state. At most one grant per cycle; one request issues per cycle (full throughput).
- Priority: D over I, except when starve_cnt == STARVE_LIMIT and I is valid, in which case I wins.
- starve_cnt:
  - increments on a D grant while i_req_valid = 1;
  - clears on an I grant or when i_req_valid = 0;
  - saturates at STARVE_LIMIT.
- Address mapping: word address = addr[ADDR_W+1:2].
- Error conditions:
  - I misaligned: addr[1:0] != 0.
  - D misaligned: addr[1:0] != 0 for a full-word write or read.
  - Out of range: addr[31:ADDR_W+2] != 0.
- An erroring request is still granted, but mem_w_enable is forced to 0; its response carries err = 1 and data = 0.
- Outputs to BRAM on a granted cycle N: mem_addr from the winner, mem_w_enable = d_req_we (D winner only, else 0), mem_w_data = d_req_wdata. Idle cycles drive mem_w_enable = 0.
- Response tracking: registers rsp_owner (NONE/I/D) and rsp_err at cycle N.
  - In cycle N+1 the owner's rsp_valid = 1 and rsp_data = mem_r_data (0 if err).
  - A store also produces a D response in N+1.
- Back-to-back issues overlap: the response to N and the grant of N+1 occur in the same cycle.
- Simultaneous I and D valid with starve_cnt < LIMIT: D granted; i_req_ready = 0, and I must hold its request stable.
- Reset (async, any time):
  - rsp_owner = NONE, starve_cnt = 0;
  - all rsp_valid = 0, rsp_data = 0, rsp_err = 0, mem_w_enable = 0;
  - an in-flight response is dropped.
- Grants are blocked while rst = 1.

Decomposition:
- Shared package (mem_pkg): rsp_owner_e enum {OWN_NONE, OWN_I, OWN_D}, BRAM_ADDR_W = 15, function addr_ok(addr, we) returning the error flag.
- One sub-module, mem_arb_prio: the combinational priority/starvation grant plus the starve_cnt register.

Test Plan:
- Single I read of 0x0000_0010 with mem word 4 = 0xDEADBEEF -> i_req_ready in cycle 0, mem_addr = 4; i_rsp_valid = 1 with 0xDEADBEEF in cycle 1; d_rsp_valid stays 0.
- D store addr 0x20, we = 0b0011, wdata 0x1234_5678 -> mem_w_enable = 0b0011, mem_addr = 8; d_rsp_valid = 1 next cycle; a following D read of 0x20 returns low half 0x5678.
- I and D both valid for 6 cycles, STARVE_LIMIT = 4 -> D, D, D, D, I, D grant sequence; starve_cnt clears after the I grant.
- D read at 0x0002_0000 (out of range) and I fetch at 0x2 (misaligned) -> mem_w_enable = 0, err = 1, data = 0 on the respective response.
- Back-to-back D reads of 0x0, 0x4, 0x8 -> d_rsp_valid for 3 consecutive cycles with data in order.
- rst asserted in the cycle after an I grant -> i_rsp_valid = 0 immediately and no late response after rst is released.
